sdram_a_ref: RTL and testbench

Periodic auto-refresh generator for the SDRAM controller. It sits directly downstream of SDRAM initialisation and starts only once init_end is high. It raises a refresh request every refresh interval and waits for the arbiter to grant it. It then issues PRECHARGE-ALL followed by AREF_NUM AUTO-REFRESH commands, observing tRP and tRC, and pulses aref_end when done. Its command, bank and address outputs go to the arbiter's command mux, which drives the SDRAM pins.

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_a_ref.sv | 134 +++++++++++++
 tb/tb_sdram_a_ref.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {CS_n,RAS_n,CAS_n,WE_n},
// idle bank/address values and the precharge/auto-refresh wait counts.
package sdram_pkg;

    localparam logic [3:0]  CMD_NOP       = 4'b0111;
    localparam logic [3:0]  CMD_P_CHARGE  = 4'b0010;
    localparam logic [3:0]  CMD_AUTO_REF  = 4'b0001;
    localparam logic [3:0]  CMD_M_REG_SET = 4'b0000;
    localparam logic [3:0]  CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0]  CMD_READ      = 4'b0101;
    localparam logic [3:0]  CMD_WRITE     = 4'b0100;
    localparam logic [3:0]  CMD_B_STOP    = 4'b0110;

    localparam logic [1:0]  DEF_BA        = 2'b11;
    localparam logic [10:0] DEF_ADDR      = 11'h7ff;   // A10 high selects all banks

    localparam logic [2:0]  TRP_CLK       = 3'd2;
    localparam logic [2:0]  TRC_CLK       = 3'd7;

endpackage

// File: rtl/sdram_a_ref.sv
// Periodic auto-refresh generator.
// Raises aref_req once per refresh interval after init_end; on grant (aref_en in
// IDLE) issues PRECHARGE-ALL, waits tRP, then AREF_NUM AUTO-REFRESH commands each
// followed by a tRC wait, and pulses aref_end.
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   init_end                SDRAM init complete (level)
//   aref_en                 arbiter grant
//   aref_req                refresh request
//   aref_cmd/ba/addr        command bus to arbiter mux (registered cmd)
//   aref_end                one-cycle done pulse
//
// state     | meaning
// AREF_IDLE | waiting for request + grant
// AREF_PCHA | precharge-all issued from this state
// AREF_TRP  | tRP wait
// AUTO_REF  | auto-refresh issued from this state
// AREF_TRF  | tRC wait after each auto-refresh
// AREF_END  | sequence done, aref_end high
module sdram_a_ref
    import sdram_pkg::*;
#(
    parameter logic [9:0] CNT_REF_MAX = 10'd749,
    parameter logic [1:0] AREF_NUM    = 2'd2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [10:0] aref_addr,
    output logic        aref_end
);

    localparam logic [2:0] AREF_IDLE = 3'd0;
    localparam logic [2:0] AREF_PCHA = 3'd1;
    localparam logic [2:0] AREF_TRP  = 3'd2;
    localparam logic [2:0] AUTO_REF  = 3'd3;
    localparam logic [2:0] AREF_TRF  = 3'd4;
    localparam logic [2:0] AREF_END  = 3'd5;

    logic [2:0] state_q, state_d;
    logic [9:0] cnt_ref_q, cnt_ref_d;
    logic [2:0] cnt_clk_q, cnt_clk_d;
    logic [1:0] cnt_aref_q, cnt_aref_d;
    logic       aref_req_q, aref_req_d;
    logic [3:0] cmd_q, cmd_d;
    logic       trp_end, trc_end;

    assign trp_end = (state_q == AREF_TRP) && (cnt_clk_q == TRP_CLK);
    assign trc_end = (state_q == AREF_TRF) && (cnt_clk_q == TRC_CLK);

    always_comb begin
        cnt_ref_d = cnt_ref_q;
        if (!init_end)
            cnt_ref_d = 10'd0;
        else if (cnt_ref_q == CNT_REF_MAX)
            cnt_ref_d = 10'd0;
        else
            cnt_ref_d = cnt_ref_q + 10'd1;
    end

    // Set has priority so an interval expiring on a grant edge is not lost.
    always_comb begin
        aref_req_d = aref_req_q;
        if (init_end && (cnt_ref_q == CNT_REF_MAX))
            aref_req_d = 1'b1;
        else if ((state_q == AREF_IDLE) && aref_en)
            aref_req_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AREF_IDLE: if (aref_en && aref_req_q) state_d = AREF_PCHA;
            AREF_PCHA: state_d = AREF_TRP;
            AREF_TRP:  if (trp_end) state_d = AUTO_REF;
            AUTO_REF:  state_d = AREF_TRF;
            AREF_TRF:  if (trc_end) state_d = (cnt_aref_q == AREF_NUM) ? AREF_END : AUTO_REF;
            AREF_END:  state_d = AREF_IDLE;
            default:   state_d = AREF_IDLE;
        endcase
    end

    always_comb begin
        cnt_clk_d = cnt_clk_q + 3'd1;
        if ((state_q == AREF_IDLE) || (state_q == AREF_END) || trp_end || trc_end)
            cnt_clk_d = 3'd0;
    end

    always_comb begin
        cnt_aref_d = cnt_aref_q;
        if (state_q == AREF_IDLE)
            cnt_aref_d = 2'd0;
        else if (state_q == AUTO_REF)
            cnt_aref_d = cnt_aref_q + 2'd1;
    end

    always_comb begin
        cmd_d = CMD_NOP;
        case (state_q)
            AREF_PCHA: cmd_d = CMD_P_CHARGE;
            AUTO_REF:  cmd_d = CMD_AUTO_REF;
            default:   cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= AREF_IDLE;
            cnt_ref_q  <= 10'd0;
            cnt_clk_q  <= 3'd0;
            cnt_aref_q <= 2'd0;
            aref_req_q <= 1'b0;
            cmd_q      <= CMD_NOP;
        end else begin
            state_q    <= state_d;
            cnt_ref_q  <= cnt_ref_d;
            cnt_clk_q  <= cnt_clk_d;
            cnt_aref_q <= cnt_aref_d;
            aref_req_q <= aref_req_d;
            cmd_q      <= cmd_d;
        end
    end

    assign aref_req  = aref_req_q;
    assign aref_cmd  = cmd_q;
    assign aref_ba   = DEF_BA;
    assign aref_addr = DEF_ADDR;
    assign aref_end  = (state_q == AREF_END);

endmodule

// File: tb/tb_sdram_a_ref.sv
// Self-checking bench for sdram_a_ref: reset values, interval timing, grant
// sequence via a vector table, ignored grants, steady-state spacing, mid-sequence reset.
module tb_sdram_a_ref;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        en_drv;
    logic        tie_mode;
    logic        aref_en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [10:0] aref_addr;
    logic        aref_end;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    assign aref_en = tie_mode ? aref_req : en_drv;

    sdram_a_ref dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .init_end  (init_end),
        .aref_en   (aref_en),
        .aref_req  (aref_req),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .aref_end  (aref_end)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic       en;
        logic       exp_req;
        logic [3:0] exp_cmd;
        logic       exp_end;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Row j: drive en before edge k+j, then outputs seen during cycle k+j+1.
    task automatic run_table(input bit hold_en);
        for (int j = 0; j < 21; j++) begin
            @(negedge sys_clk);
            en_drv = hold_en ? 1'b1 : tbl[j].en;
            tick();
            check($sformatf("tbl%0d_req", j), {31'd0, aref_req}, {31'd0, tbl[j].exp_req});
            check($sformatf("tbl%0d_cmd", j), {28'd0, aref_cmd}, {28'd0, tbl[j].exp_cmd});
            check($sformatf("tbl%0d_end", j), {31'd0, aref_end}, {31'd0, tbl[j].exp_end});
        end
        @(negedge sys_clk);
        en_drv = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!aref_req && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, init_cyc, bad, c1, c2, ends;

        for (int j = 0; j < 21; j++) begin
            tbl[j].en      = (j == 0);
            tbl[j].exp_req = 1'b0;
            tbl[j].exp_cmd = (j == 1) ? 4'b0010 : ((j == 4 || j == 12) ? 4'b0001 : 4'b0111);
            tbl[j].exp_end = (j == 19);
        end

        sys_rst_n = 1'b0; init_end = 1'b0; en_drv = 1'b0; tie_mode = 1'b0;
        repeat (3) tick();
        check("rst_req",  {31'd0, aref_req}, 32'd0);
        check("rst_cmd",  {28'd0, aref_cmd}, 32'h7);
        check("rst_ba",   {30'd0, aref_ba},  32'h3);
        check("rst_addr", {21'd0, aref_addr}, 32'h7ff);
        check("rst_end",  {31'd0, aref_end}, 32'd0);

        // No init: nothing happens for 2000 cycles, even with stray grants.
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            en_drv = (i % 97 == 5);
            tick();
            if (aref_req !== 1'b0 || aref_cmd !== 4'b0111 || aref_end !== 1'b0) bad++;
        end
        check("noinit_quiet", bad, 0);

        // First request 750 edges after init_end is seen.
        @(negedge sys_clk);
        en_drv = 1'b0;
        init_end = 1'b1;
        init_cyc = cyc;
        wait_req(n);
        check("first_req_delay", n, 750);

        // Pending request survives a further wrap without a grant.
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (aref_req !== 1'b1 || aref_cmd !== 4'b0111) bad++;
        end
        check("req_held", bad, 0);

        run_table(1'b0);

        // Missed interval not queued: next request on the next interval boundary.
        wait_req(n);
        check("second_req_cyc", cyc - init_cyc, 2250);

        // Grant held high across the whole sequence: still exactly one sequence.
        run_table(1'b1);

        // Grants while no request is pending are ignored.
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            en_drv = (i % 3 != 0);
            tick();
            if (aref_req !== 1'b0 || aref_cmd !== 4'b0111 || aref_end !== 1'b0) bad++;
        end
        check("stray_en_ignored", bad, 0);
        @(negedge sys_clk);
        en_drv = 1'b0;

        // Steady state: grant follows request immediately.
        tie_mode = 1'b1;
        n = 0;
        while (aref_cmd !== 4'b0010 && n < 2000) begin tick(); n++; end
        check("steady_first_pcha_seen", {31'd0, (aref_cmd === 4'b0010)}, 32'd1);
        c1 = cyc;
        ends = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (aref_end === 1'b1) ends++;
        end while (aref_cmd !== 4'b0010 && n < 2000);
        c2 = cyc;
        check("pcha_spacing", c2 - c1, 750);
        check("ends_per_grant", ends, 1);

        // Reset during AREF_TRF: outputs drop asynchronously.
        n = 0;
        while (aref_cmd !== 4'b0001 && n < 40) begin tick(); n++; end
        check("in_trf_cmd", {28'd0, aref_cmd}, 32'h1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_req",  {31'd0, aref_req}, 32'd0);
        check("arst_cmd",  {28'd0, aref_cmd}, 32'h7);
        check("arst_ba",   {30'd0, aref_ba},  32'h3);
        check("arst_addr", {21'd0, aref_addr}, 32'h7ff);
        check("arst_end",  {31'd0, aref_end}, 32'd0);
        tie_mode = 1'b0;
        en_drv = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_req(n);
        check("post_rst_req_delay", n, 750);
        check("post_rst_cmd", {28'd0, aref_cmd}, 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
